// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the memory bus arbiter.
// Default widths follow the SoC's 32-bit address and data buses.
package mem_bus_arbiter_pkg;

  localparam int unsigned SocAddrW = 32;
  localparam int unsigned SocDataW = 32;
  localparam int unsigned TmoW     = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr_i, wrapping once.
module mem_bus_arbiter_rr_pick #(
  parameter int unsigned NM   = 3,
  parameter int unsigned IdxW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0]   req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NM-1:0]   onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [2*NM-1:0] dbl;

  always_comb begin
    dbl      = {req_i, req_i};
    idx_o    = '0;
    onehot_o = '0;
    any_o    = |req_i;
    // Scan downwards so the lowest qualifying position is the last one written.
    for (int i = int'(2 * NM) - 1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(ptr_i))) begin
        idx_o = IdxW'(i % NM);
      end
    end
    for (int i = 0; i < int'(NM); i++) begin
      onehot_o[i] = any_o && (idx_o == IdxW'(i));
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port slave bus between NM masters,
// one outstanding transaction at a time, with a timeout against silent slaves.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NM      = 3,
  parameter int unsigned AW      = SocAddrW,
  parameter int unsigned DW      = SocDataW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_wdata_i,
  output logic [NM-1:0]    m_gnt_o,
  output logic [NM-1:0]    m_rvalid_o,
  output logic [NM-1:0]    m_err_o,
  output logic [DW-1:0]    m_rdata_o,
  output logic             s_req_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_addr_o,
  output logic [DW-1:0]    s_wdata_o,
  input  logic             s_ready_i,
  input  logic             s_rvalid_i,
  input  logic [DW-1:0]    s_rdata_i,
  output logic             busy_o
);

  localparam int unsigned IdxW = (NM > 1) ? $clog2(NM) : 1;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic [NM-1:0]   pick_onehot;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic [AW-1:0]   pick_addr;
  logic [DW-1:0]   pick_wdata;
  logic [NM-1:0]   sel_oh;
  logic [IdxW-1:0] ptr_next;
  logic            exit_now, tmo_hit, tmo_abort;

  mem_bus_arbiter_rr_pick #(
    .NM   (NM),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i    (m_req_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    sel_oh     = '0;
    for (int i = 0; i < int'(NM); i++) begin
      if (pick_onehot[i]) begin
        pick_addr  = m_addr_i[i*AW +: AW];
        pick_wdata = m_wdata_i[i*DW +: DW];
      end
      sel_oh[i] = (sel_q == IdxW'(i));
    end
  end

  assign ptr_next  = (sel_q == IdxW'(NM - 1)) ? '0 : sel_q + 1'b1;
  assign exit_now  = ((state_q == StReq) && s_ready_i) || ((state_q == StWait) && s_rvalid_i);
  assign tmo_hit   = (state_q != StIdle) && (tmo_q == TmoW'(TIMEOUT));
  // A normal completion in the timeout cycle takes precedence over the abort.
  assign tmo_abort = tmo_hit && !exit_now;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          we_d    = |(m_we_i & pick_onehot);
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          tmo_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        tmo_d = tmo_q + 1'b1;
        if (s_ready_i) begin
          if (we_q) begin
            rr_ptr_d = ptr_next;
            state_d  = StIdle;
          end else begin
            state_d = StWait;
          end
        end else if (tmo_abort) begin
          rr_ptr_d = ptr_next;
          state_d  = StIdle;
        end
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (s_rvalid_i || tmo_abort) begin
          rr_ptr_d = ptr_next;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign s_req_o    = (state_q == StReq) && !tmo_abort;
  assign s_we_o     = (state_q == StReq) && we_q;
  assign s_addr_o   = (state_q == StReq) ? addr_q : '0;
  assign s_wdata_o  = (state_q == StReq) ? wdata_q : '0;
  assign m_gnt_o    = ((state_q == StReq) && s_ready_i) ? sel_oh : '0;
  assign m_rvalid_o = ((state_q == StWait) && s_rvalid_i) ? sel_oh : '0;
  assign m_rdata_o  = ((state_q == StWait) && s_rvalid_i) ? s_rdata_i : '0;
  assign m_err_o    = tmo_abort ? sel_oh : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int NM  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]    s_addr;
  logic             s_req, s_we, s_ready, s_rvalid, busy;

  int n_tests  = 0;
  int n_fail   = 0;
  int mdl_ptr  = 0;
  int prev_gnt = -1;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NM      (NM),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_req_i    (m_req),
    .m_we_i     (m_we),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_err_o    (m_err),
    .m_rdata_o  (m_rdata),
    .s_req_o    (s_req),
    .s_we_o     (s_we),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_ready_i  (s_ready),
    .s_rvalid_i (s_rvalid),
    .s_rdata_i  (s_rdata),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    @(posedge clk); #1;
    chk("rst_out", {busy, s_req, s_we, s_addr, s_wdata, m_gnt, m_rvalid, m_err, m_rdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; mdl_ptr = 0; prev_gnt = -1;
  endtask

  task automatic idle_check(input string tag);
    m_req = '0; s_ready = 1'($urandom); s_rvalid = 1'($urandom); s_rdata = $urandom;
    @(negedge clk);
    chk(tag, {busy, s_req, m_gnt, m_rvalid, m_err, m_rdata}, '0);
    @(posedge clk); #1;
    s_ready = 1'b0; s_rvalid = 1'b0;
  endtask

  // Runs one transaction starting in an IDLE cycle with m_req already driven.
  // rdy_dly / rv_dly < 0 mean the slave never answers in that phase.
  task automatic do_txn(input int rdy_dly, input int rv_dly, input logic [DW-1:0] rdata,
                        input bit drop_early, input bit scramble, output int gnt_idx);
    int win, t, rv_at;
    bit in_wait, done, exit_c, tmo_c;
    logic e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [NM-1:0] e_oh, req_pick, others;
    win = -1; gnt_idx = -1;
    for (int k = 0; k < NM; k++) begin
      int c;
      c = (mdl_ptr + k) % NM;
      if (win < 0 && m_req[c]) win = c;
    end
    if (win < 0) return;
    e_oh = '0; e_oh[win] = 1'b1; req_pick = m_req;
    e_we = m_we[win]; e_addr = m_addr[win*AW +: AW]; e_wdata = m_wdata[win*DW +: DW];
    s_ready = 1'($urandom); s_rvalid = 1'($urandom); s_rdata = $urandom;
    @(negedge clk);
    chk("idle_out", {busy, s_req, m_gnt, m_rvalid, m_err, m_rdata}, '0);
    @(posedge clk); #1;
    if (drop_early) begin
      m_req[win] = 1'b0; m_addr[win*AW +: AW] = 32'h200;
    end
    t = 0; in_wait = 0; done = 0; rv_at = -1;
    while (!done) begin
      if (scramble) begin
        for (int i = 0; i < NM; i++) begin
          m_addr[i*AW +: AW] = $urandom; m_wdata[i*DW +: DW] = $urandom; m_we[i] = 1'($urandom);
        end
      end
      if (!in_wait) begin
        s_ready = (t == rdy_dly); s_rvalid = 1'($urandom);
      end else begin
        s_ready = 1'($urandom); s_rvalid = (t == rv_at);
      end
      s_rdata = (in_wait && s_rvalid) ? rdata : $urandom;
      @(negedge clk);
      exit_c = in_wait ? s_rvalid : s_ready;
      tmo_c  = (t == TMO) && !exit_c;
      chk("busy", busy, 1'b1);
      chk("s_req", s_req, !in_wait && !tmo_c);
      if (!in_wait && !tmo_c) chk("s_bus", {s_we, s_addr, s_wdata}, {e_we, e_addr, e_wdata});
      chk("m_gnt", m_gnt, (!in_wait && exit_c) ? e_oh : '0);
      chk("m_rvalid", m_rvalid, (in_wait && exit_c) ? e_oh : '0);
      chk("m_rdata", m_rdata, (in_wait && exit_c) ? rdata : '0);
      chk("m_err", m_err, tmo_c ? e_oh : '0);
      if (!in_wait && exit_c) begin
        for (int k = 0; k < NM; k++) if (m_gnt[k]) gnt_idx = k;
        if (gnt_idx >= 0) begin
          others = req_pick; others[gnt_idx] = 1'b0;
          chk("fair", (prev_gnt == gnt_idx) && (others != '0), 1'b0);
          prev_gnt = gnt_idx;
        end
      end
      @(posedge clk); #1;
      if (!in_wait && exit_c) begin
        m_req[win] = 1'b0;
        if (e_we) done = 1;
        else begin
          in_wait = 1;
          rv_at = (rv_dly < 0) ? -1 : t + 1 + rv_dly;
        end
      end else if (in_wait && exit_c) begin
        done = 1;
      end
      if (tmo_c) begin
        done = 1; m_req[win] = 1'b0; prev_gnt = -1;
      end
      t++;
    end
    mdl_ptr = (win + 1) % NM;
    s_ready = 1'b0; s_rvalid = 1'b0;
  endtask

  initial begin
    int idx;
    logic [NM-1:0] r;
    int rd, rv;
    // 1: single read by master 1
    do_reset();
    m_req = 3'b010; m_we = '0; m_addr[1*AW +: AW] = 32'h100;
    do_txn(0, 0, 32'hDEADBEEF, 0, 0, idx);
    chk("t1_idx", idx, 1);
    idle_check("t1_idle");
    // 2: all masters request reads continuously
    do_reset();
    for (int i = 0; i < 6; i++) begin
      m_req = 3'b111; m_we = '0;
      for (int k = 0; k < NM; k++) m_addr[k*AW +: AW] = $urandom;
      do_txn(0, 0, $urandom, 0, 0, idx);
      chk("t2_order", idx, i % 3);
    end
    // 3: write with a slow slave while live inputs wiggle
    m_req = 3'b100; m_we = 3'b100;
    m_addr[2*AW +: AW] = 32'h40; m_wdata[2*DW +: DW] = 32'h55;
    do_txn(3, 0, '0, 0, 1, idx);
    idle_check("t3_idle");
    // 4: timeouts in WAIT and REQ, then boundary cases where the exit lands on TMO
    m_req = 3'b001; m_we = '0;
    do_txn(0, -1, '0, 0, 0, idx);
    m_req = 3'b011; m_we = '0;
    do_txn(0, 0, 32'h1234_5678, 0, 0, idx);
    chk("t4_next", idx, 1);
    m_req = 3'b100;
    do_txn(-1, 0, '0, 0, 0, idx);
    m_req = 3'b001; m_we = 3'b001;
    do_txn(TMO, 0, '0, 0, 0, idx);
    m_req = 3'b010; m_we = '0;
    do_txn(0, TMO - 1, 32'hCAFE_F00D, 0, 0, idx);
    // 5: master 1 drops its request after latch
    m_req = 3'b010; m_we = '0; m_addr[1*AW +: AW] = 32'h300;
    do_txn(2, 1, 32'hA5A5_0001, 1, 0, idx);
    chk("t5_idx", idx, 1);
    // 6: asynchronous reset during WAIT
    m_req = 3'b001; m_we = '0; s_ready = 1'b0; s_rvalid = 1'b0;
    @(negedge clk);
    chk("t6_idle", busy, 1'b0);
    @(posedge clk); #1; s_ready = 1'b1;
    @(negedge clk);
    chk("t6_gnt", m_gnt, 3'b001);
    @(posedge clk); #1; m_req = '0; s_ready = 1'b0;
    @(negedge clk);
    chk("t6_wait", busy, 1'b1);
    #2; rst_n = 1'b0; s_rvalid = 1'b1; s_ready = 1'b1; s_rdata = 32'h7777_7777;
    #1;
    chk("t6_async", {busy, s_req, s_we, s_addr, s_wdata, m_gnt, m_rvalid, m_err, m_rdata}, '0);
    @(posedge clk); #1; rst_n = 1'b1; mdl_ptr = 0; prev_gnt = -1; s_ready = 1'b0;
    @(negedge clk);
    chk("t6_late", {busy, m_rvalid, m_rdata}, '0);
    @(posedge clk); #1; s_rvalid = 1'b0;
    m_req = 3'b111;
    do_txn(0, 0, $urandom, 0, 0, idx);
    chk("t6_ptr0", idx, 0);
    // Randomized traffic; requesters keep holding until granted.
    m_req = '0;
    for (int it = 0; it < 80; it++) begin
      r = 3'($urandom);
      m_req = m_req | r;
      if (m_req == '0) m_req = 3'b001;
      for (int k = 0; k < NM; k++) begin
        if (r[k]) begin
          m_we[k] = 1'($urandom); m_addr[k*AW +: AW] = $urandom; m_wdata[k*DW +: DW] = $urandom;
        end
      end
      rd = $urandom_range(0, 3);
      rv = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) rv = -1;
      if ($urandom_range(0, 19) == 0) rd = -1;
      do_txn(rd, rv, $urandom, 0, 1'($urandom), idx);
    end
    idle_check("end_idle");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
